// File: rtl/ws2812_arb_pkg.sv
// Shared state encoding, bus widths and default timing constants for the WS2812 frame arbiter.
package ws2812_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StArb  = 2'd1,
      StRun  = 2'd2,
      StGap  = 2'd3
   } arb_state_e;

   localparam int unsigned CFG_NUM_W           = 6;
   localparam int unsigned CFG_DATA_W          = 24;
   localparam int unsigned GAP_CYC_DEFAULT     = 3_000;
   localparam int unsigned TIMEOUT_CYC_DEFAULT = 500_000;

   // Index of the set bit in a one-hot vector of up to 8 requesters; 0 when empty.
   function automatic int unsigned onehot_idx(input logic [7:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping circularly.
module rr_pick #(
   parameter int unsigned NREQ = 3
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
   output logic [NREQ-1:0]         pick_o,
   output logic                    valid_o
);

   localparam int unsigned PtrW = $clog2(NREQ);

   int               idx;
   logic [PtrW-1:0]  sel;

   always_comb begin
      pick_o  = '0;
      valid_o = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         idx = int'(rr_ptr_i) + i;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         sel = PtrW'(idx);
         if (!valid_o && req_i[sel]) begin
            pick_o[sel] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one ws2812_ctrl driver among NREQ producers.
// Define WS2812_ARB_GAP_EN to insert a GAP_CYC latch gap after every completed frame.
module ws2812_frame_arbiter
   import ws2812_arb_pkg::*;
#(
   parameter int unsigned NREQ        = 3,
   parameter int unsigned LED_NUM     = 64,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
   parameter int unsigned GAP_CYC     = GAP_CYC_DEFAULT
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   input  logic [NREQ-1:0]              req_i,
   input  logic [NREQ*CFG_NUM_W-1:0]    req_cfg_num_i,
   input  logic [NREQ*CFG_DATA_W-1:0]   req_cfg_data_i,
   input  logic                         cfg_start_i,
   output logic                         ws2812_start_o,
   output logic [CFG_NUM_W-1:0]         cfg_num_o,
   output logic [CFG_DATA_W-1:0]        cfg_data_o,
   output logic [NREQ-1:0]              req_cfg_start_o,
   output logic [NREQ-1:0]              grant_o,
   output logic                         frame_done_o,
   output logic                         timeout_err_o
);

   localparam int unsigned PtrW  = $clog2(NREQ);
   localparam int unsigned WdogW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned GapW  = $clog2(GAP_CYC + 1);

`ifdef WS2812_ARB_GAP_EN
   localparam arb_state_e StAfterFrame = StGap;
`else
   localparam arb_state_e StAfterFrame = StIdle;
`endif

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [6:0]       led_cnt_q, led_cnt_d;
   logic [WdogW-1:0] wdog_q, wdog_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic             frame_done_q, frame_done_d;
   logic             timeout_q, timeout_d;

   logic [NREQ-1:0]  pick;
   logic             pick_vld;
   logic [7:0]       grant_ext;
   int unsigned      grant_idx;
   logic [PtrW-1:0]  next_ptr;

   rr_pick #(
      .NREQ(NREQ)
   ) u_rr_pick (
      .req_i   (req_i),
      .rr_ptr_i(rr_ptr_q),
      .pick_o  (pick),
      .valid_o (pick_vld)
   );

   assign grant_ext = 8'(grant_q);
   assign grant_idx = onehot_idx(grant_ext);
   assign next_ptr  = (grant_idx >= NREQ - 1) ? '0 : PtrW'(grant_idx + 1);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      led_cnt_d    = led_cnt_q;
      wdog_d       = '0;
      gap_d        = '0;
      frame_done_d = 1'b0;
      timeout_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (|req_i) state_d = StArb;
         end
         StArb: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (cfg_start_i) begin
               if (led_cnt_q == 7'(LED_NUM - 1)) begin
                  frame_done_d = 1'b1;
                  grant_d      = '0;
                  rr_ptr_d     = next_ptr;
                  led_cnt_d    = '0;
                  state_d      = StAfterFrame;
               end else begin
                  led_cnt_d = led_cnt_q + 7'd1;
               end
            end else if (wdog_q == WdogW'(TIMEOUT_CYC - 1)) begin
               // Driver stalled: abort the frame and move fairness past the grantee.
               timeout_d = 1'b1;
               grant_d   = '0;
               rr_ptr_d  = next_ptr;
               led_cnt_d = '0;
               state_d   = StIdle;
            end else begin
               wdog_d = wdog_q + WdogW'(1);
            end
         end
         StGap: begin
            if (gap_q == GapW'(GAP_CYC - 1)) state_d = StIdle;
            else gap_d = gap_q + GapW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         led_cnt_q    <= '0;
         wdog_q       <= '0;
         gap_q        <= '0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         led_cnt_q    <= led_cnt_d;
         wdog_q       <= wdog_d;
         gap_q        <= gap_d;
         frame_done_q <= frame_done_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      cfg_num_o  = '0;
      cfg_data_o = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant_q[i]) begin
            cfg_num_o  = cfg_num_o | req_cfg_num_i[i*CFG_NUM_W +: CFG_NUM_W];
            cfg_data_o = cfg_data_o | req_cfg_data_i[i*CFG_DATA_W +: CFG_DATA_W];
         end
      end
   end

   assign ws2812_start_o  = (state_q == StRun);
   assign req_cfg_start_o = {NREQ{cfg_start_i}} & grant_q;
   assign grant_o         = grant_q;
   assign frame_done_o    = frame_done_q;
   assign timeout_err_o   = timeout_q;

endmodule
